// File: rtl/ledpanel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ledpanel_pkg
//   Shared types and helpers for the ledpanel write-port arbiter.
//   gamma8 is used only when LEDPANEL_GAMMA_EN is defined.
//   Revision: 1.0  initial release
// ---------------------------------------------------------------------------
package ledpanel_pkg;

  localparam int COORD_W_DEFAULT = 5;
  localparam int RGB_W           = 24;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_HOST = 2'd1,
    GNT_FILL = 2'd2
  } grant_e;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_e;

  // Gamma-2.2 curve sampled every 16 codes (index 16 is full scale).
  function automatic logic [7:0] gamma_knot(input logic [4:0] idx);
    logic [7:0] r;
    case (idx)
      5'd0:    r = 8'd0;
      5'd1:    r = 8'd1;
      5'd2:    r = 8'd3;
      5'd3:    r = 8'd6;
      5'd4:    r = 8'd12;
      5'd5:    r = 8'd20;
      5'd6:    r = 8'd29;
      5'd7:    r = 8'd41;
      5'd8:    r = 8'd55;
      5'd9:    r = 8'd72;
      5'd10:   r = 8'd91;
      5'd11:   r = 8'd112;
      5'd12:   r = 8'd135;
      5'd13:   r = 8'd161;
      5'd14:   r = 8'd190;
      5'd15:   r = 8'd221;
      default: r = 8'd255;
    endcase
    return r;
  endfunction

  // 256-entry gamma ROM, built as linear interpolation between the knots.
  function automatic logic [7:0] gamma8(input logic [7:0] v);
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [11:0] span;
    lo   = gamma_knot({1'b0, v[7:4]});
    hi   = gamma_knot({1'b0, v[7:4]} + 5'd1);
    span = ({4'd0, hi} - {4'd0, lo}) * {8'd0, v[3:0]};
    return lo + span[11:4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ledpanel_rect_walker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ledpanel_rect_walker
//   Latches a rectangle (corners in any order) and walks it row by row,
//   x fastest. last flags the bottom-right pixel (xmax,ymax).
//   Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module ledpanel_rect_walker
  import ledpanel_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               last
);

  logic [COORD_W-1:0] xmin;
  logic [COORD_W-1:0] xmax;
  logic [COORD_W-1:0] ymax;

  // Latch the sorted bounds on load; step the cursor on each granted pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xmin  <= '0;
      xmax  <= '0;
      ymax  <= '0;
      cur_x <= '0;
      cur_y <= '0;
    end else if (load) begin
      xmin  <= (x0 < x1) ? x0 : x1;
      xmax  <= (x0 < x1) ? x1 : x0;
      ymax  <= (y0 < y1) ? y1 : y0;
      cur_x <= (x0 < x1) ? x0 : x1;
      cur_y <= (y0 < y1) ? y0 : y1;
    end else if (advance) begin
      if (cur_x == xmax) begin
        cur_x <= xmin;
        // Stop at the final row so the counter never wraps past the panel edge.
        if (cur_y != ymax) begin
          cur_y <= cur_y + 1'b1;
        end
      end else begin
        cur_x <= cur_x + 1'b1;
      end
    end
  end

  assign last = (cur_x == xmax) && (cur_y == ymax);

endmodule
`default_nettype wire

// File: rtl/ledpanel_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ledpanel_wr_arbiter
//   Owns the ledpanel pixel write port. Arbitrates between a host single-pixel
//   channel and a rectangle-fill engine (round-robin or host priority) and
//   issues at most one pixel per clock through a registered output stage.
//   Optional feature: LEDPANEL_GAMMA_EN adds a gamma-2.2 colour stage and one
//   extra cycle of output latency.
//   Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module ledpanel_wr_arbiter
  import ledpanel_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter bit FAIR    = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [COORD_W-1:0] host_x,
  input  logic [COORD_W-1:0] host_y,
  input  logic [RGB_W-1:0]   host_rgb,
  input  logic               fill_start,
  input  logic               fill_abort,
  input  logic [COORD_W-1:0] fill_x0,
  input  logic [COORD_W-1:0] fill_x1,
  input  logic [COORD_W-1:0] fill_y0,
  input  logic [COORD_W-1:0] fill_y1,
  input  logic [RGB_W-1:0]   fill_rgb,
  output logic               fill_busy,
  output logic               fill_done,
  output logic               wr_enable,
  output logic [COORD_W-1:0] wr_addr_x,
  output logic [COORD_W-1:0] wr_addr_y,
  output logic [RGB_W-1:0]   wr_rgb_data
);

  fill_state_e        state;
  fill_state_e        state_nxt;
  grant_e             grant;
  grant_e             last_grant;
  logic               fill_req;
  logic               walker_load;
  logic               walker_last;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic [RGB_W-1:0]   fill_colour;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [RGB_W-1:0]   pix_rgb;

  ledpanel_rect_walker #(
    .COORD_W (COORD_W)
  ) u_walker (
    .clk     (clk),
    .resetn  (resetn),
    .load    (walker_load),
    .advance (grant == GNT_FILL),
    .x0      (fill_x0),
    .x1      (fill_x1),
    .y0      (fill_y0),
    .y1      (fill_y1),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .last    (walker_last)
  );

  // Fill state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= FILL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Per-cycle grant decision and fill next-state. An abort withdraws the fill
  // request so no fill pixel is issued in that cycle.
  always_comb begin
    state_nxt = state;
    grant     = GNT_NONE;
    fill_req  = (state == FILL_RUN) && !fill_abort;
    if (host_valid && (!fill_req || !FAIR || (last_grant == GNT_FILL))) begin
      grant = GNT_HOST;
    end else if (fill_req) begin
      grant = GNT_FILL;
    end
    case (state)
      FILL_IDLE: begin
        if (fill_start) begin
          state_nxt = FILL_RUN;
        end
      end
      FILL_RUN: begin
        if (fill_abort) begin
          state_nxt = FILL_IDLE;
        end else if ((grant == GNT_FILL) && walker_last) begin
          state_nxt = FILL_IDLE;
        end
      end
      default: state_nxt = FILL_IDLE;
    endcase
  end

  assign walker_load = (state == FILL_IDLE) && fill_start;
  assign host_ready  = (grant == GNT_HOST);
  assign fill_busy   = (state == FILL_RUN);
  assign fill_done   = (grant == GNT_FILL) && walker_last;

  // Remember the last winner (only real grants count) and the fill colour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant  <= GNT_FILL;
      fill_colour <= '0;
    end else begin
      if (grant != GNT_NONE) begin
        last_grant <= grant;
      end
      if (walker_load) begin
        fill_colour <= fill_rgb;
      end
    end
  end

  // Select the pixel belonging to the current winner.
  always_comb begin
    pix_x   = cur_x;
    pix_y   = cur_y;
    pix_rgb = fill_colour;
    if (grant == GNT_HOST) begin
      pix_x   = host_x;
      pix_y   = host_y;
      pix_rgb = host_rgb;
    end
  end

`ifdef LEDPANEL_GAMMA_EN
  logic               s1_en;
  logic [COORD_W-1:0] s1_x;
  logic [COORD_W-1:0] s1_y;
  logic [RGB_W-1:0]   s1_rgb;

  // First output stage: capture the granted pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_en  <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_rgb <= '0;
    end else begin
      s1_en <= (grant != GNT_NONE);
      if (grant != GNT_NONE) begin
        s1_x   <= pix_x;
        s1_y   <= pix_y;
        s1_rgb <= pix_rgb;
      end
    end
  end

  // Second output stage: gamma-correct each channel; hold data when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_enable   <= 1'b0;
      wr_addr_x   <= '0;
      wr_addr_y   <= '0;
      wr_rgb_data <= '0;
    end else begin
      wr_enable <= s1_en;
      if (s1_en) begin
        wr_addr_x   <= s1_x;
        wr_addr_y   <= s1_y;
        wr_rgb_data <= {gamma8(s1_rgb[23:16]), gamma8(s1_rgb[15:8]), gamma8(s1_rgb[7:0])};
      end
    end
  end
`else
  // Output stage: register the granted pixel; hold data when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_enable   <= 1'b0;
      wr_addr_x   <= '0;
      wr_addr_y   <= '0;
      wr_rgb_data <= '0;
    end else begin
      wr_enable <= (grant != GNT_NONE);
      if (grant != GNT_NONE) begin
        wr_addr_x   <= pix_x;
        wr_addr_y   <= pix_y;
        wr_rgb_data <= pix_rgb;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ledpanel_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ledpanel_wr_arbiter
//   Two arbiters (FAIR=0 and FAIR=1) driven by the same stimulus and compared
//   every cycle against a pixel-queue reference model.
//   Honours LEDPANEL_GAMMA_EN for colour mapping and output latency.
//   Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tb_ledpanel_wr_arbiter;
  import ledpanel_pkg::*;

  localparam int CW = 5;
`ifdef LEDPANEL_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          host_valid = 1'b0;
  logic [CW-1:0] host_x = '0;
  logic [CW-1:0] host_y = '0;
  logic [23:0]   host_rgb = '0;
  logic          fill_start = 1'b0;
  logic          fill_abort = 1'b0;
  logic [CW-1:0] fill_x0 = '0;
  logic [CW-1:0] fill_x1 = '0;
  logic [CW-1:0] fill_y0 = '0;
  logic [CW-1:0] fill_y1 = '0;
  logic [23:0]   fill_rgb = '0;

  logic [1:0]    hr;
  logic [1:0]    fb;
  logic [1:0]    fd;
  logic [1:0]    we;
  logic [CW-1:0] wx [2];
  logic [CW-1:0] wy [2];
  logic [23:0]   wd [2];

  always #5 clk = ~clk;

  // Index 0: host priority, index 1: round-robin.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ledpanel_wr_arbiter #(.COORD_W(CW), .FAIR(g == 1)) dut (
      .clk(clk), .resetn(resetn),
      .host_valid(host_valid), .host_ready(hr[g]),
      .host_x(host_x), .host_y(host_y), .host_rgb(host_rgb),
      .fill_start(fill_start), .fill_abort(fill_abort),
      .fill_x0(fill_x0), .fill_x1(fill_x1), .fill_y0(fill_y0), .fill_y1(fill_y1),
      .fill_rgb(fill_rgb), .fill_busy(fb[g]), .fill_done(fd[g]),
      .wr_enable(we[g]), .wr_addr_x(wx[g]), .wr_addr_y(wy[g]), .wr_rgb_data(wd[g])
    );
  end

  // Reference model: pending fill pixels as a list, plus the expected output pipe.
  logic [2*CW-1:0] pix [2][1024];
  int              head [2];
  int              cnt [2];
  logic [23:0]     m_rgb [2];
  bit              last_fill [2];
  bit              pe_en [2][2];
  logic [CW-1:0]   pe_x [2][2];
  logic [CW-1:0]   pe_y [2][2];
  logic [23:0]     pe_d [2][2];
  int              done_cyc [2];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;

  function automatic logic [23:0] cmap(input logic [23:0] c);
`ifdef LEDPANEL_GAMMA_EN
    return {gamma8(c[23:16]), gamma8(c[15:8]), gamma8(c[7:0])};
`else
    return c;
`endif
  endfunction

  task automatic check1(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      head[d] = 0;
      cnt[d] = 0;
      m_rgb[d] = '0;
      last_fill[d] = 1'b1;
      for (int s = 0; s < 2; s++) begin
        pe_en[d][s] = 1'b0;
        pe_x[d][s] = '0;
        pe_y[d][s] = '0;
        pe_d[d][s] = '0;
      end
    end
  endtask

  task automatic load_rect(input int d);
    int xa, xb, ya, yb;
    xa = (fill_x0 < fill_x1) ? int'(fill_x0) : int'(fill_x1);
    xb = (fill_x0 < fill_x1) ? int'(fill_x1) : int'(fill_x0);
    ya = (fill_y0 < fill_y1) ? int'(fill_y0) : int'(fill_y1);
    yb = (fill_y0 < fill_y1) ? int'(fill_y1) : int'(fill_y0);
    head[d] = 0;
    cnt[d] = 0;
    for (int y = ya; y <= yb; y++) begin
      for (int x = xa; x <= xb; x++) begin
        pix[d][cnt[d]] = {CW'(x), CW'(y)};
        cnt[d]++;
      end
    end
    m_rgb[d] = fill_rgb;
  endtask

  task automatic check_zero();
    for (int d = 0; d < 2; d++) begin
      check1("rst_host_ready", d, hr[d], 0);
      check1("rst_fill_busy", d, fb[d], 0);
      check1("rst_fill_done", d, fd[d], 0);
      check1("rst_wr_enable", d, we[d], 0);
      check1("rst_wr_addr_x", d, wx[d], 0);
      check1("rst_wr_addr_y", d, wy[d], 0);
      check1("rst_wr_rgb", d, wd[d], 0);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit busy, freq, gh, gf;
      busy = cnt[d] > 0;
      freq = busy && !fill_abort;
      gh   = host_valid && (!freq || (d == 0) || last_fill[d]);
      gf   = freq && !gh;
      check1("host_ready", d, hr[d], gh);
      check1("fill_busy", d, fb[d], busy);
      check1("fill_done", d, fd[d], gf && (cnt[d] == 1));
      check1("wr_enable", d, we[d], pe_en[d][LAT-1]);
      check1("wr_addr_x", d, wx[d], pe_x[d][LAT-1]);
      check1("wr_addr_y", d, wy[d], pe_y[d][LAT-1]);
      check1("wr_rgb", d, wd[d], pe_d[d][LAT-1]);
      if (fd[d] === 1'b1) done_cyc[d] = cyc;
      for (int s = LAT - 1; s > 0; s--) begin
        pe_en[d][s] = pe_en[d][s-1];
        if (pe_en[d][s-1]) begin
          pe_x[d][s] = pe_x[d][s-1];
          pe_y[d][s] = pe_y[d][s-1];
          pe_d[d][s] = pe_d[d][s-1];
        end
      end
      pe_en[d][0] = gh || gf;
      if (gh) begin
        pe_x[d][0] = host_x;
        pe_y[d][0] = host_y;
        pe_d[d][0] = cmap(host_rgb);
        last_fill[d] = 1'b0;
      end else if (gf) begin
        {pe_x[d][0], pe_y[d][0]} = pix[d][head[d]];
        pe_d[d][0] = cmap(m_rgb[d]);
        head[d]++;
        cnt[d]--;
        last_fill[d] = 1'b1;
      end
      if (busy && fill_abort) cnt[d] = 0;
      else if (!busy && fill_start) load_rect(d);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int bound);
    for (int k = 0; k < bound && (fb[0] === 1'b1 || fb[1] === 1'b1); k++) step();
    for (int d = 0; d < 2; d++) check1("idle_within_bound", d, fb[d], 0);
  endtask

  task automatic start_fill(input int x0, input int x1, input int y0, input int y1);
    fill_x0 = CW'(x0);
    fill_x1 = CW'(x1);
    fill_y0 = CW'(y0);
    fill_y1 = CW'(y1);
    fill_rgb = 24'($urandom);
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
  endtask

  initial begin
    int s, t;
    model_reset();
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    resetn = 1'b1;
    step();

    // Single host write.
    host_valid = 1'b1;
    host_x = 5'd3;
    host_y = 5'd4;
    host_rgb = 24'hFF0000;
    step();
    host_valid = 1'b0;
    repeat (LAT - 1) step();
    for (int d = 0; d < 2; d++) begin
      check1("host_wr_enable", d, we[d], 1);
      check1("host_wr_x", d, wx[d], 3);
      check1("host_wr_y", d, wy[d], 4);
      check1("host_wr_rgb", d, wd[d], cmap(24'hFF0000));
    end

    // Three-pixel fill with reversed x corners.
    s = cyc;
    start_fill(2, 0, 5, 5);
    repeat (5) step();
    for (int d = 0; d < 2; d++) check1("small_fill_done_cycle", d, done_cyc[d] - s, 3);

    // Full panel with host continuously requesting.
    host_valid = 1'b1;
    s = cyc;
    start_fill(0, 31, 31, 0);
    for (int k = 0; k < 2047; k++) begin
      host_x = CW'($urandom);
      host_y = CW'($urandom);
      host_rgb = 24'($urandom);
      step();
    end
    check1("fair_full_done_cycle", 1, done_cyc[1] - s, 2047);
    check1("fair_full_busy_after", 1, fb[1], 0);
    check1("prio_fill_stalled", 0, fb[0], 1);
    check1("prio_no_done_yet", 0, done_cyc[0] > s, 0);
    host_valid = 1'b0;
    t = cyc;
    repeat (1024) step();
    check1("prio_full_done_cycle", 0, done_cyc[0] - t, 1023);
    run_until_idle(10);

    // Abort after ten fill pixels, then a fresh fill.
    s = cyc;
    start_fill(0, 31, 0, 31);
    repeat (10) step();
    fill_abort = 1'b1;
    step();
    fill_abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check1("abort_busy_low", d, fb[d], 0);
      check1("abort_no_done", d, done_cyc[d] > s, 0);
    end
    s = cyc;
    start_fill(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    run_until_idle(40);
    for (int d = 0; d < 2; d++) check1("refill_done", d, done_cyc[d] > s, 1);

    // Randomized mixed traffic.
    for (int k = 0; k < 400; k++) begin
      host_valid = 1'($urandom);
      host_x = CW'($urandom);
      host_y = CW'($urandom);
      host_rgb = 24'($urandom);
      fill_start = ($urandom_range(0, 7) == 0);
      fill_abort = ($urandom_range(0, 63) == 0);
      fill_x0 = CW'($urandom);
      fill_x1 = CW'($urandom);
      fill_y0 = CW'($urandom_range(0, 7));
      fill_y1 = CW'($urandom_range(0, 7));
      fill_rgb = 24'($urandom);
      step();
    end
    host_valid = 1'b0;
    fill_start = 1'b0;
    fill_abort = 1'b0;
    run_until_idle(1100);

    // Asynchronous reset in the middle of a fill.
    start_fill(0, 31, 0, 31);
    repeat (20) step();
    #2;
    resetn = 1'b0;
    #1;
    check_zero();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (10) step();
    for (int d = 0; d < 2; d++) check1("post_reset_busy", d, fb[d], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
